// File: rtl/fifo_read_drain.sv
// rtl/fifo_read_drain.sv - FIFO read-side drain into a 2-entry skid buffer with registered valid/ready output
// Optional word_count transfer counter compiled in with `define FIFO_RD_STATS_EN.
module fifo_read_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  read_clk,
  input  logic                  reset,
  input  logic                  mem_empty,
  input  logic [DATA_WIDTH-1:0] fifo_out,
  output logic                  read_en,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  word_count
`endif
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t                state_q, state_d;
  logic                  inflight;
  logic [1:0]            occ, occ_d, occ_after_pop;
  logic [DATA_WIDTH-1:0] ent0, ent1;
  logic                  valid_q;
  logic                  pop, arrive, room;

  assign data_out   = ent0;
  assign data_valid = valid_q;

  always_comb begin
    pop           = valid_q && data_ready;
    arrive        = inflight && (state_q == RUN) && !flush;
    occ_after_pop = occ - {1'b0, pop};
    // Outstanding words (buffered + in flight) after this cycle's pop must leave a free slot.
    room          = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    read_en       = !reset && !flush && (state_q == RUN) && !mem_empty && room;

    state_d = state_q;
    if (flush) begin
      state_d = DRAIN;
    end else if ((state_q == DRAIN) && !inflight) begin
      state_d = RUN;
    end

    occ_d = occ;
    if (flush) begin
      occ_d = 2'd0;
    end else begin
      occ_d = occ_after_pop + {1'b0, arrive};
    end
  end

  always_ff @(posedge read_clk) begin
    if (reset) begin
      state_q  <= RUN;
      inflight <= 1'b0;
      occ      <= 2'd0;
      valid_q  <= 1'b0;
      ent0     <= '0;
      ent1     <= '0;
    end else begin
      state_q  <= state_d;
      inflight <= read_en;
      occ      <= occ_d;
      valid_q  <= (occ_d != 2'd0);
      if (!flush) begin
        if (pop) begin
          ent0 <= ent1;
        end
        // Arrival lands behind whatever survives the pop; a later write to ent0 overrides the shift.
        if (arrive) begin
          if (occ_after_pop == 2'd0) begin
            ent0 <= fifo_out;
          end else begin
            ent1 <= fifo_out;
          end
        end
      end
    end
  end

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge read_clk) begin
    if (reset) begin
      word_count <= '0;
    end else if (pop) begin
      word_count <= word_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_read_drain.sv
// tb/tb_fifo_read_drain.sv - self-checking bench for fifo_read_drain (FIFO_RD_STATS_EN optional)
module tb_fifo_read_drain;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst, fl, rdy, me;
  logic [DW-1:0] fo;
  logic          read_en, data_valid;
  logic [DW-1:0] data_out;
`ifdef FIFO_RD_STATS_EN
  logic [CW-1:0] word_count;
`endif

  fifo_read_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .read_clk   (clk),
    .reset      (rst),
    .mem_empty  (me),
    .fifo_out   (fo),
    .read_en    (read_en),
    .flush      (fl),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (rdy)
`ifdef FIFO_RD_STATS_EN
    ,
    .word_count (word_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            p;
  } ent_t;

  typedef struct {
    bit            rdy;
    bit            re;
    bit            v;
    logic [DW-1:0] d;
  } vec_t;

  int            n_cmp, n_bad;
  ent_t          mq[$];
  logic [DW-1:0] fq[$];
  logic [DW-1:0] got[$];
  int            e, cnt;
  bit            drain, last_re;
  logic          s_re, s_valid;
  logic [DW-1:0] s_dout;
  int            s_wc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, e);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    me = 1'b0;
  endtask

  // Model: outstanding words popped from the FIFO, each stamped with its pop edge; a word is
  // visible downstream from the second edge after its pop, and at most two may be outstanding.
  task automatic tick();
    bit            ev, pop, ere, re_s;
    logic [DW-1:0] w;
    ent_t          t;
    @(negedge clk);
    ev  = (mq.size() > 0) && (mq[0].p < e);
    pop = ev && rdy;
    ere = !rst && !fl && !drain && !me && ((mq.size() - (pop ? 1 : 0)) < 2);
    s_re    = read_en;
    s_valid = data_valid;
    s_dout  = data_out;
`ifdef FIFO_RD_STATS_EN
    s_wc = int'(word_count);
    chk("word_count", word_count, cnt);
`endif
    chk("data_valid", data_valid, ev);
    if (ev) chk("data_out", data_out, mq[0].d);
    chk("read_en", read_en, ere);
    if (data_valid && rdy && !rst) got.push_back(data_out);
    re_s = read_en;
    @(posedge clk);
    e++;
    w = '0;
    if (re_s && fq.size() > 0) w = fq.pop_front();
    if (rst) begin
      mq.delete();
      drain = 1'b0;
      cnt   = 0;
    end else begin
      if (pop) cnt = (cnt + 1) % (1 << CW);
      if (fl) begin
        mq.delete();
        drain = 1'b1;
      end else begin
        if (drain && !last_re) drain = 1'b0;
        if (pop) void'(mq.pop_front());
        if (re_s) begin
          t.d = w;
          t.p = e;
          mq.push_back(t);
        end
      end
    end
    last_re = rst ? 1'b0 : re_s;
    #1;
    fo = re_s ? w : DW'($urandom);
    me = (fq.size() == 0);
  endtask

  task automatic run_until(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(nm, got.size(), n);
  endtask

  vec_t          tbl[7];
  logic [DW-1:0] first_after;

  initial begin
    clk = 0; rst = 1; fl = 0; rdy = 0; me = 1; fo = '0;
    n_cmp = 0; n_bad = 0; e = 0; cnt = 0; drain = 0; last_re = 0; s_wc = 0;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 8'h11};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 8'h22};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 8'h33};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 8'h44};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h00};

    tick(); tick();
    rst = 0;

    // Reset then idle with the FIFO empty.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_dout", s_dout, 8'h00);
    end

    // Streaming table.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    for (int i = 0; i < 7; i++) begin
      rdy = tbl[i].rdy;
      tick();
      chk("tbl_read_en", s_re, tbl[i].re);
      chk("tbl_valid", s_valid, tbl[i].v);
      if (tbl[i].v) chk("tbl_data", s_dout, tbl[i].d);
    end

    // Back-pressure: 8 words, ready low for 5 cycles mid-stream.
    got.delete();
    for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
    rdy = 1;
    tick(); tick(); tick();
    rdy = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_re", s_re, 1'b0);
    end
    rdy = 1;
    run_until(8, 40, "bp_count");
    for (int i = 0; i < 8 && i < got.size(); i++) chk("bp_order", got[i], 8'hA0 + 8'(i));

    // Flush while streaming with a read in flight.
    for (int i = 0; i < 6; i++) push(8'hB0 + 8'(i));
    tick(); tick(); tick();
    fl = 1;
    tick();
    fl = 0;
    first_after = fq[0];
    got.delete();
    tick();
    chk("flush_valid", s_valid, 1'b0);
    chk("flush_re", s_re, 1'b0);
    run_until(1, 20, "flush_resume");
    if (got.size() > 0) chk("flush_first", got[0], first_after);
    run_until(fq.size() + mq.size() + got.size(), 30, "flush_tail");
    for (int i = 0; i < 10; i++) tick();

    // Flush with the skid buffer full.
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    rdy = 0;
    for (int i = 0; i < 4; i++) tick();
    fl = 1;
    tick();
    fl = 0;
    tick();
    chk("flush_full_valid", s_valid, 1'b0);
    rdy = 1;
    for (int i = 0; i < 10; i++) tick();

    // Reset mid-stream.
    for (int i = 0; i < 6; i++) push(8'hD0 + 8'(i));
    tick(); tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    tick();
    chk("rst_valid", s_valid, 1'b0);
    chk("rst_dout", s_dout, 8'h00);
    for (int i = 0; i < 12; i++) tick();

`ifdef FIFO_RD_STATS_EN
    rst = 1; tick(); rst = 0;
    got.delete();
    for (int i = 0; i < 17; i++) push(8'(i));
    run_until(17, 60, "stats_xfers");
    tick();
    chk("stats_wrap", s_wc, 1);
    fl = 1; tick(); fl = 0; tick();
    chk("stats_flush", s_wc, 1);
    rst = 1; tick(); rst = 0; tick();
    chk("stats_reset", s_wc, 0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) != 0 && fq.size() < 20) push(DW'($urandom));
      tick();
    end
    rst = 0; fl = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
